// File: rtl/combat_referee.sv
// combat_referee: frame-rate referee for a two-player fighting game.
// Resolves attack reach, hit/block classification, damage, stun flags,
// KO / draw detection and round restart.
// Optional round timer is built only when the macro ROUND_TIMER_EN is defined;
// without it time_left is tied to 0 and a round ends only by KO.

// One attacker's view of the exchange: reach test, once-per-attack latch,
// and the damage it would deal to the opposing player.
module combat_referee_striker #(
    parameter int I_RANGE = 32,
    parameter int D_RANGE = 48
) (
    input  logic       logic_clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       fight,
    input  logic [9:0] gap,
    input  logic [3:0] atk_state,
    input  logic [3:0] def_state,
    output logic       hit_connect,
    output logic       hit_block,
    output logic [1:0] damage
);
    logic latched;
    logic swinging;
    logic in_reach;

    assign swinging    = (atk_state == 4'd4) || (atk_state == 4'd7);
    assign in_reach    = ((atk_state == 4'd4) && (gap <= 10'(I_RANGE))) ||
                         ((atk_state == 4'd7) && (gap <= 10'(D_RANGE)));
    assign hit_connect = in_reach && fight && !latched;
    // Walking backward or already in blockstun counts as guarding.
    assign hit_block   = (def_state == 4'd2) || (def_state == 4'd10);
    assign damage      = (hit_connect && !hit_block) ?
                         ((atk_state == 4'd7) ? 2'd2 : 2'd1) : 2'd0;

    // Latch a connect until the active frames end so one swing lands once.
    always_ff @(posedge logic_clk or posedge reset) begin
        if (reset)
            latched <= 1'b0;
        else if (clear)
            latched <= 1'b0;
        else if (hit_connect)
            latched <= 1'b1;
        else if (!swinging)
            latched <= 1'b0;
    end
endmodule

module combat_referee #(
    parameter int PLAYER_WIDTH   = 64,
    parameter int I_RANGE        = 32,
    parameter int D_RANGE        = 48,
    parameter int MAX_HEALTH     = 3,
    parameter int ROUND_SECONDS  = 60,
    parameter int FRAMES_PER_SEC = 60
) (
    input  logic       logic_clk,
    input  logic       reset,
    input  logic       restart,
    input  logic [9:0] p1_pos_x,
    input  logic [9:0] p2_pos_x,
    input  logic [3:0] p1_state,
    input  logic [3:0] p2_state,
    output logic [1:0] p1_stunmode,
    output logic [1:0] p2_stunmode,
    output logic [1:0] p1_health,
    output logic [1:0] p2_health,
    output logic [1:0] game_state,
    output logic [6:0] time_left
);
    typedef enum logic [1:0] {FIGHT = 2'd0, P1_WIN = 2'd1, P2_WIN = 2'd2, DRAW = 2'd3} game_t;

    localparam logic [1:0] HP_FULL = 2'(MAX_HEALTH);

    game_t gs;

    // Index 0 is P1, index 1 is P2 throughout.
    logic [1:0][3:0] st;
    logic [1:0]      connect;
    logic [1:0]      block;
    logic [1:0][1:0] dmg;
    logic [1:0][1:0] hp;
    logic [1:0][1:0] hp_nxt;
    logic [1:0][1:0] stun;
    logic [1:0][1:0] stun_nxt;
    logic [1:0]      ko;

    logic signed [10:0] gap_raw;
    logic [9:0]         gap;
    logic               fight;
    logic               clear;

    assign st    = {p2_state, p1_state};
    assign fight = (gs == FIGHT);
    assign clear = restart && !fight;

    // Sprites overlap when the raw gap goes negative; that is still point-blank.
    assign gap_raw = $signed({1'b0, p2_pos_x}) - $signed({1'b0, p1_pos_x})
                   - $signed(11'(PLAYER_WIDTH));
    assign gap     = gap_raw[10] ? 10'd0 : gap_raw[9:0];

    genvar i;
    generate
        for (i = 0; i < 2; i++) begin : g_striker
            combat_referee_striker #(
                .I_RANGE (I_RANGE),
                .D_RANGE (D_RANGE)
            ) u_striker (
                .logic_clk   (logic_clk),
                .reset       (reset),
                .clear       (clear),
                .fight       (fight),
                .gap         (gap),
                .atk_state   (st[i]),
                .def_state   (st[1-i]),
                .hit_connect (connect[i]),
                .hit_block   (block[i]),
                .damage      (dmg[i])
            );
        end
    endgenerate

    // Damage and stun landing on each player come from the opposite striker.
    always_comb begin
        hp_nxt   = hp;
        stun_nxt = '0;
        ko       = '0;
        for (int p = 0; p < 2; p++) begin
            hp_nxt[p]   = (dmg[1-p] >= hp[p]) ? 2'd0 : hp[p] - dmg[1-p];
            stun_nxt[p] = connect[1-p] ? (block[1-p] ? 2'b10 : 2'b01) : 2'b00;
            ko[p]       = (hp_nxt[p] == 2'd0);
        end
    end

`ifdef ROUND_TIMER_EN
    localparam int FCW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

    logic [FCW-1:0] frame_cnt;
    logic [6:0]     time_reg;
    logic           wrap;
    logic           timeout;

    assign wrap      = (frame_cnt == FCW'(FRAMES_PER_SEC - 1));
    assign timeout   = wrap && (time_reg == 7'd1);
    assign time_left = time_reg;
`else
    // Timer configuration has no consumer in this build.
    logic [31:0] unused_timer_cfg;
    assign unused_timer_cfg = 32'(ROUND_SECONDS + FRAMES_PER_SEC);
    assign time_left        = 7'd0;
`endif

    // Round FSM: applies landed hits, decides KO/timeout, freezes after game over.
    always_ff @(posedge logic_clk or posedge reset) begin
        if (reset) begin
            gs   <= FIGHT;
            hp   <= {HP_FULL, HP_FULL};
            stun <= '0;
`ifdef ROUND_TIMER_EN
            frame_cnt <= '0;
            time_reg  <= 7'(ROUND_SECONDS);
`endif
        end else if (gs == FIGHT) begin
            hp   <= hp_nxt;
            stun <= stun_nxt;
`ifdef ROUND_TIMER_EN
            frame_cnt <= wrap ? '0 : frame_cnt + 1'b1;
            time_reg  <= wrap ? time_reg - 7'd1 : time_reg;
`endif
            // KO outranks the clock on a shared edge.
            if (ko[0] && ko[1])
                gs <= DRAW;
            else if (ko[0])
                gs <= P2_WIN;
            else if (ko[1])
                gs <= P1_WIN;
`ifdef ROUND_TIMER_EN
            else if (timeout)
                gs <= (hp_nxt[0] > hp_nxt[1]) ? P1_WIN :
                      (hp_nxt[0] < hp_nxt[1]) ? P2_WIN : DRAW;
`endif
        end else begin
            stun <= '0;
            if (restart) begin
                gs <= FIGHT;
                hp <= {HP_FULL, HP_FULL};
`ifdef ROUND_TIMER_EN
                frame_cnt <= '0;
                time_reg  <= 7'(ROUND_SECONDS);
`endif
            end
        end
    end

    assign p1_stunmode = stun[0];
    assign p2_stunmode = stun[1];
    assign p1_health   = hp[0];
    assign p2_health   = hp[1];
    assign game_state  = gs;
endmodule

// File: tb/tb_combat_referee.sv
// Directed testbench for combat_referee: reach, block, damage, trade/draw,
// KO, restart, mid-round reset and (when ROUND_TIMER_EN is defined) timeout.
module tb_combat_referee;
    logic       logic_clk = 1'b0;
    logic       reset     = 1'b1;
    logic       restart   = 1'b0;
    logic [9:0] p1_pos_x  = 10'd10;
    logic [9:0] p2_pos_x  = 10'd100;
    logic [3:0] p1_state  = 4'd0;
    logic [3:0] p2_state  = 4'd0;
    logic [1:0] p1_stunmode, p2_stunmode, p1_health, p2_health, game_state;
    logic [6:0] time_left;

    int n_checks = 0;
    int n_fail   = 0;

    combat_referee #(.ROUND_SECONDS(2)) dut (
        .logic_clk   (logic_clk),
        .reset       (reset),
        .restart     (restart),
        .p1_pos_x    (p1_pos_x),
        .p2_pos_x    (p2_pos_x),
        .p1_state    (p1_state),
        .p2_state    (p2_state),
        .p1_stunmode (p1_stunmode),
        .p2_stunmode (p2_stunmode),
        .p1_health   (p1_health),
        .p2_health   (p2_health),
        .game_state  (game_state),
        .time_left   (time_left)
    );

    always #5 logic_clk = ~logic_clk;

    task automatic tick();
        @(posedge logic_clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; restart = 1'b0; p1_state = 4'd0; p2_state = 4'd0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_checks++; if (p1_stunmode !== 2'b00) begin n_fail++; $display("FAIL reset p1_stunmode got %b want 00", p1_stunmode); end
        n_checks++; if (p2_stunmode !== 2'b00) begin n_fail++; $display("FAIL reset p2_stunmode got %b want 00", p2_stunmode); end
        n_checks++; if (p1_health !== 2'd3) begin n_fail++; $display("FAIL reset p1_health got %0d want 3", p1_health); end
        n_checks++; if (p2_health !== 2'd3) begin n_fail++; $display("FAIL reset p2_health got %0d want 3", p2_health); end
        n_checks++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL reset game_state got %0d want 0", game_state); end
`ifdef ROUND_TIMER_EN
        n_checks++; if (time_left !== 7'd2) begin n_fail++; $display("FAIL reset time_left got %0d want 2", time_left); end
`else
        n_checks++; if (time_left !== 7'd0) begin n_fail++; $display("FAIL reset time_left got %0d want 0", time_left); end
`endif
        reset = 1'b0;
    endtask

    // gap 26, neutral attack held two cycles: single hit, one-cycle stun
    task automatic test_neutral_hit();
        apply_reset();
        p1_pos_x = 10'd10; p2_pos_x = 10'd100; p1_state = 4'd4;
        tick();
        n_checks++; if (p2_stunmode !== 2'b01) begin n_fail++; $display("FAIL neutral p2_stunmode got %b want 01", p2_stunmode); end
        n_checks++; if (p2_health !== 2'd2) begin n_fail++; $display("FAIL neutral p2_health got %0d want 2", p2_health); end
        n_checks++; if (p1_stunmode !== 2'b00) begin n_fail++; $display("FAIL neutral p1_stunmode got %b want 00", p1_stunmode); end
        n_checks++; if (p1_health !== 2'd3) begin n_fail++; $display("FAIL neutral p1_health got %0d want 3", p1_health); end
        tick();
        n_checks++; if (p2_stunmode !== 2'b00) begin n_fail++; $display("FAIL neutral_2nd p2_stunmode got %b want 00", p2_stunmode); end
        n_checks++; if (p2_health !== 2'd2) begin n_fail++; $display("FAIL neutral_2nd p2_health got %0d want 2", p2_health); end
        p1_state = 4'd0;
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n_checks++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL restart_in_fight game_state got %0d want 0", game_state); end
        n_checks++; if (p2_health !== 2'd2) begin n_fail++; $display("FAIL restart_in_fight p2_health got %0d want 2", p2_health); end
    endtask

    task automatic test_block();
        apply_reset();
        p1_pos_x = 10'd10; p2_pos_x = 10'd100; p2_state = 4'd2; p1_state = 4'd4;
        tick();
        n_checks++; if (p2_stunmode !== 2'b10) begin n_fail++; $display("FAIL block_back p2_stunmode got %b want 10", p2_stunmode); end
        n_checks++; if (p2_health !== 2'd3) begin n_fail++; $display("FAIL block_back p2_health got %0d want 3", p2_health); end
        tick();
        n_checks++; if (p2_stunmode !== 2'b00) begin n_fail++; $display("FAIL block_back_2nd p2_stunmode got %b want 00", p2_stunmode); end
        p1_state = 4'd0; p2_state = 4'd10;
        tick();
        p1_state = 4'd4;
        tick();
        n_checks++; if (p2_stunmode !== 2'b10) begin n_fail++; $display("FAIL block_stun p2_stunmode got %b want 10", p2_stunmode); end
        n_checks++; if (p2_health !== 2'd3) begin n_fail++; $display("FAIL block_stun p2_health got %0d want 3", p2_health); end
        p1_state = 4'd0; p2_state = 4'd0;
        tick();
    endtask

    task automatic test_directional();
        apply_reset();
        p1_pos_x = 10'd10; p2_pos_x = 10'd150; p1_state = 4'd7;
        tick();
        n_checks++; if (p2_stunmode !== 2'b00) begin n_fail++; $display("FAIL dir_far p2_stunmode got %b want 00", p2_stunmode); end
        n_checks++; if (p2_health !== 2'd3) begin n_fail++; $display("FAIL dir_far p2_health got %0d want 3", p2_health); end
        p1_state = 4'd0;
        tick();
        p2_pos_x = 10'd120; p1_state = 4'd7;
        tick();
        n_checks++; if (p2_stunmode !== 2'b01) begin n_fail++; $display("FAIL dir_hit p2_stunmode got %b want 01", p2_stunmode); end
        n_checks++; if (p2_health !== 2'd1) begin n_fail++; $display("FAIL dir_hit p2_health got %0d want 1", p2_health); end
        tick();
        n_checks++; if (p2_stunmode !== 2'b00) begin n_fail++; $display("FAIL dir_hold2 p2_stunmode got %b want 00", p2_stunmode); end
        tick();
        n_checks++; if (p2_stunmode !== 2'b00) begin n_fail++; $display("FAIL dir_hold3 p2_stunmode got %b want 00", p2_stunmode); end
        n_checks++; if (p2_health !== 2'd1) begin n_fail++; $display("FAIL dir_hold3 p2_health got %0d want 1", p2_health); end
        p1_state = 4'd0;
        tick();
    endtask

    // Reach edges: gap 33 misses neutral, 32 lands; gap 49 misses directional, 48 lands.
    task automatic test_reach_boundary();
        apply_reset();
        p1_pos_x = 10'd10; p2_pos_x = 10'd107; p1_state = 4'd4;
        tick();
        n_checks++; if (p2_stunmode !== 2'b00) begin n_fail++; $display("FAIL reach_i33 p2_stunmode got %b want 00", p2_stunmode); end
        p1_state = 4'd0; tick();
        p2_pos_x = 10'd106; p1_state = 4'd4;
        tick();
        n_checks++; if (p2_stunmode !== 2'b01) begin n_fail++; $display("FAIL reach_i32 p2_stunmode got %b want 01", p2_stunmode); end
        n_checks++; if (p2_health !== 2'd2) begin n_fail++; $display("FAIL reach_i32 p2_health got %0d want 2", p2_health); end
        p1_state = 4'd0; tick();
        p2_pos_x = 10'd123; p1_state = 4'd7;
        tick();
        n_checks++; if (p2_stunmode !== 2'b00) begin n_fail++; $display("FAIL reach_d49 p2_stunmode got %b want 00", p2_stunmode); end
        p1_state = 4'd0; tick();
        p2_pos_x = 10'd122; p1_state = 4'd7;
        tick();
        n_checks++; if (p2_health !== 2'd0) begin n_fail++; $display("FAIL reach_d48 p2_health got %0d want 0", p2_health); end
        n_checks++; if (game_state !== 2'd1) begin n_fail++; $display("FAIL reach_d48 game_state got %0d want 1", game_state); end
        p1_state = 4'd0; tick();
    endtask

    // Saturating KO, frozen game-over, restart, then P2 hitting through overlap.
    task automatic test_ko_saturate();
        apply_reset();
        p1_pos_x = 10'd10; p2_pos_x = 10'd120; p1_state = 4'd7;
        tick();
        p1_state = 4'd0; tick();
        p1_state = 4'd7;
        tick();
        n_checks++; if (p2_health !== 2'd0) begin n_fail++; $display("FAIL ko_sat p2_health got %0d want 0", p2_health); end
        n_checks++; if (game_state !== 2'd1) begin n_fail++; $display("FAIL ko_sat game_state got %0d want 1", game_state); end
        p1_state = 4'd0; tick();
        n_checks++; if (p2_stunmode !== 2'b00) begin n_fail++; $display("FAIL ko_after p2_stunmode got %b want 00", p2_stunmode); end
        p1_state = 4'd7;
        tick();
        n_checks++; if (p2_stunmode !== 2'b00) begin n_fail++; $display("FAIL frozen p2_stunmode got %b want 00", p2_stunmode); end
        n_checks++; if (p2_health !== 2'd0) begin n_fail++; $display("FAIL frozen p2_health got %0d want 0", p2_health); end
        n_checks++; if (game_state !== 2'd1) begin n_fail++; $display("FAIL frozen game_state got %0d want 1", game_state); end
        p1_state = 4'd0; restart = 1'b1;
        tick();
        restart = 1'b0;
        n_checks++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL ko_restart game_state got %0d want 0", game_state); end
        n_checks++; if (p2_health !== 2'd3) begin n_fail++; $display("FAIL ko_restart p2_health got %0d want 3", p2_health); end
        p1_pos_x = 10'd100; p2_pos_x = 10'd50; p2_state = 4'd4;
        tick();
        n_checks++; if (p1_stunmode !== 2'b01) begin n_fail++; $display("FAIL overlap p1_stunmode got %b want 01", p1_stunmode); end
        n_checks++; if (p1_health !== 2'd2) begin n_fail++; $display("FAIL overlap p1_health got %0d want 2", p1_health); end
        p2_state = 4'd0; tick();
    endtask

    task automatic test_trade_draw();
        apply_reset();
        p1_pos_x = 10'd10; p2_pos_x = 10'd120; p1_state = 4'd7;
        tick();
        p1_state = 4'd0; tick();
        p2_state = 4'd7;
        tick();
        n_checks++; if (p1_health !== 2'd1) begin n_fail++; $display("FAIL trade_setup p1_health got %0d want 1", p1_health); end
        n_checks++; if (p2_health !== 2'd1) begin n_fail++; $display("FAIL trade_setup p2_health got %0d want 1", p2_health); end
        p2_state = 4'd0; tick();
        p1_pos_x = 10'd100; p2_pos_x = 10'd164; p1_state = 4'd4; p2_state = 4'd4;
        tick();
        n_checks++; if (p1_stunmode !== 2'b01) begin n_fail++; $display("FAIL trade p1_stunmode got %b want 01", p1_stunmode); end
        n_checks++; if (p2_stunmode !== 2'b01) begin n_fail++; $display("FAIL trade p2_stunmode got %b want 01", p2_stunmode); end
        n_checks++; if (p1_health !== 2'd0) begin n_fail++; $display("FAIL trade p1_health got %0d want 0", p1_health); end
        n_checks++; if (p2_health !== 2'd0) begin n_fail++; $display("FAIL trade p2_health got %0d want 0", p2_health); end
        n_checks++; if (game_state !== 2'd3) begin n_fail++; $display("FAIL trade game_state got %0d want 3", game_state); end
        p1_state = 4'd0; p2_state = 4'd0;
        tick();
        n_checks++; if (p1_stunmode !== 2'b00) begin n_fail++; $display("FAIL draw_hold p1_stunmode got %b want 00", p1_stunmode); end
        n_checks++; if (game_state !== 2'd3) begin n_fail++; $display("FAIL draw_hold game_state got %0d want 3", game_state); end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n_checks++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL draw_restart game_state got %0d want 0", game_state); end
        n_checks++; if (p1_health !== 2'd3) begin n_fail++; $display("FAIL draw_restart p1_health got %0d want 3", p1_health); end
        n_checks++; if (p2_health !== 2'd3) begin n_fail++; $display("FAIL draw_restart p2_health got %0d want 3", p2_health); end
    endtask

    // Reset lands between the sampled connect and its registered stun.
    task automatic test_reset_midround();
        apply_reset();
        p1_pos_x = 10'd10; p2_pos_x = 10'd100; p1_state = 4'd4;
        #2 reset = 1'b1;
        tick();
        p1_state = 4'd0;
        reset = 1'b0;
        tick();
        n_checks++; if (p2_stunmode !== 2'b00) begin n_fail++; $display("FAIL midreset p2_stunmode got %b want 00", p2_stunmode); end
        n_checks++; if (p2_health !== 2'd3) begin n_fail++; $display("FAIL midreset p2_health got %0d want 3", p2_health); end
        n_checks++; if (p1_health !== 2'd3) begin n_fail++; $display("FAIL midreset p1_health got %0d want 3", p1_health); end
        n_checks++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL midreset game_state got %0d want 0", game_state); end
    endtask

    task automatic test_timer();
        apply_reset();
        p1_pos_x = 10'd10; p2_pos_x = 10'd100; p1_state = 4'd4;
        tick();
        p1_state = 4'd0;
        n_checks++; if (p2_health !== 2'd2) begin n_fail++; $display("FAIL timer_setup p2_health got %0d want 2", p2_health); end
`ifdef ROUND_TIMER_EN
        repeat (58) tick();
        n_checks++; if (time_left !== 7'd2) begin n_fail++; $display("FAIL timer_59 time_left got %0d want 2", time_left); end
        tick();
        n_checks++; if (time_left !== 7'd1) begin n_fail++; $display("FAIL timer_60 time_left got %0d want 1", time_left); end
        repeat (59) tick();
        n_checks++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL timer_119 game_state got %0d want 0", game_state); end
        tick();
        n_checks++; if (game_state !== 2'd1) begin n_fail++; $display("FAIL timer_120 game_state got %0d want 1", game_state); end
        n_checks++; if (time_left !== 7'd0) begin n_fail++; $display("FAIL timer_120 time_left got %0d want 0", time_left); end
        tick();
        n_checks++; if (time_left !== 7'd0) begin n_fail++; $display("FAIL timer_frozen time_left got %0d want 0", time_left); end
`else
        repeat (130) tick();
        n_checks++; if (time_left !== 7'd0) begin n_fail++; $display("FAIL no_timer time_left got %0d want 0", time_left); end
        n_checks++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL no_timer game_state got %0d want 0", game_state); end
`endif
    endtask

    initial begin
        test_reset();
        test_neutral_hit();
        test_block();
        test_directional();
        test_reach_boundary();
        test_ko_saturate();
        test_trade_draw();
        test_reset_midround();
        test_timer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
